// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-oriented SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int SPI_WIDTH   = 8;
  localparam int SPI_CLK_DIV = 4;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period divider plus edge counter, running only while enabled.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int   WIDTH   = SPI_WIDTH,
  parameter int   CLK_DIV = SPI_CLK_DIV,
  parameter logic CPOL    = 1'b0
) (
  input  logic clk,
  input  logic asyncR,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic last_edge
);

  localparam int HW = clog2(CLK_DIV);
  localparam int EW = clog2(2 * WIDTH + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WIDTH - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [EW-1:0] edge_q, edge_d;
  logic          sclk_q, sclk_d;
  logic          tick_s;

  // edge_q counts edges already produced, so an even count means the next edge is a leading one
  assign tick_s      = en && (hcnt_q == {HW{1'b0}});
  assign lead_pulse  = tick_s && !edge_q[0];
  assign trail_pulse = tick_s && edge_q[0];
  assign last_edge   = tick_s && (edge_q == EDGE_LAST);
  assign sclk        = sclk_q;

  // Divider and edge counter next-state
  always_comb begin
    hcnt_d = hcnt_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (clr) begin
      hcnt_d = HALF_LAST;
      edge_d = {EW{1'b0}};
      sclk_d = CPOL;
    end else if (tick_s) begin
      hcnt_d = HALF_LAST;
      edge_d = edge_q + EW'(1);
      sclk_d = ~sclk_q;
    end else if (en) begin
      hcnt_d = hcnt_q - HW'(1);
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Counter and sclk registers
  always_ff @(posedge clk or negedge asyncR) begin
    if (!asyncR) begin
      hcnt_q <= HALF_LAST;
      edge_q <= {EW{1'b0}};
      sclk_q <= CPOL;
    end else begin
      hcnt_q <= hcnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master: one word per valid/ready handshake, MSB first,
// received word returned with a one-cycle rx_valid pulse.
module spi_master
  import spi_pkg::*;
#(
  parameter int   WIDTH   = SPI_WIDTH,
  parameter int   CLK_DIV = SPI_CLK_DIV,
  parameter logic CPOL    = 1'b0,
  parameter logic CPHA    = 1'b0
) (
  input  logic             clk,
  input  logic             asyncR,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int HW = clog2(CLK_DIV);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  spi_state_t       state_q, state_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;

  logic accept_s, in_xfer_s;
  logic lead_s, trail_s, last_edge_s;
  logic sample_s, shift_s;

  assign accept_s  = tx_valid && tx_ready_q;
  assign in_xfer_s = (state_q == XFER);

  spi_sclk_gen #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk         (clk),
    .asyncR      (asyncR),
    .en          (in_xfer_s),
    .clr         (!in_xfer_s),
    .sclk        (sclk),
    .lead_pulse  (lead_s),
    .trail_pulse (trail_s),
    .last_edge   (last_edge_s)
  );

  // CPHA=0 preloads the MSB at accept, so the final trailing edge must not shift
  assign sample_s = CPHA ? trail_s : lead_s;
  assign shift_s  = CPHA ? lead_s : (trail_s && !last_edge_s);

  // State and output registers
  always_ff @(posedge clk or negedge asyncR) begin
    if (!asyncR) begin
      state_q    <= IDLE;
      cnt_q      <= {HW{1'b0}};
      tx_sr_q    <= {WIDTH{1'b0}};
      rx_sr_q    <= {WIDTH{1'b0}};
      rx_data_q  <= {WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  // Frame sequencing: SETUP and HOLD each last CLK_DIV cycles via cnt
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SETUP;
          cnt_d   = HALF_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == {HW{1'b0}}) begin
          state_d = XFER;
        end else begin
          cnt_d = cnt_q - HW'(1);
        end
      end
      XFER: begin
        if (last_edge_s) begin
          state_d = HOLD;
          cnt_d   = HALF_LAST;
        end else begin
          state_d = XFER;
        end
      end
      HOLD: begin
        if (cnt_q == {HW{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {HW{1'b0}};
      end
    endcase
  end

  // Datapath and registered outputs, all derived from the upcoming state
  always_comb begin
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    mosi_d     = mosi_q;
    cs_n_d     = (state_d == IDLE);
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    rx_valid_d = (state_q == HOLD) && (state_d == IDLE);
    if ((state_q == IDLE) && accept_s) begin
      if (CPHA) begin
        tx_sr_d = tx_data;
      end else begin
        tx_sr_d = {tx_data[WIDTH-2:0], 1'b0};
        mosi_d  = tx_data[WIDTH-1];
      end
    end else if (state_q == XFER) begin
      if (shift_s) begin
        mosi_d  = tx_sr_q[WIDTH-1];
        tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
      end else begin
        tx_sr_d = tx_sr_q;
      end
      if (sample_s) begin
        rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
      end else begin
        rx_sr_d = rx_sr_q;
      end
    end else if (rx_valid_d) begin
      rx_data_d = rx_sr_q;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
